// File: rtl/cpu_rf_wport_arb_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// Register index and data widths, the r0 constant, the multi-cycle result
// entry layout and the scheduler state encoding.
package cpu_rf_wport_arb_pkg;

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned DataW    = 32;
  localparam int unsigned NumRegs  = 32;

  localparam logic [RegAddrW-1:0] RegZero = '0;

  // One queued multi-cycle result.
  typedef struct packed {
    logic [RegAddrW-1:0] addr;
    logic [DataW-1:0]    data;
  } mc_entry_t;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWait   = 2'd1,
    StStarve = 2'd2
  } sched_state_e;

endpackage

// File: rtl/cpu_rf_wport_arb_if.sv
// Pipeline-side signal bundle of the write-port arbiter.
//   master : pipeline / multi-cycle unit side (drives requests, sees grants)
//   slave  : arbiter side
// Groups writeback, multi-cycle result, decode and register-file write signals.
interface cpu_rf_wport_arb_if;
  import cpu_rf_wport_arb_pkg::*;

  logic                cpu_stall;
  logic                wb_rfw;
  logic [RegAddrW-1:0] wb_rf_waddr;
  logic [DataW-1:0]    wb_rf_wdata;
  logic                mc_valid;
  logic [RegAddrW-1:0] mc_waddr;
  logic [DataW-1:0]    mc_wdata;
  logic                mc_ready;
  logic                id_valid;
  logic [RegAddrW-1:0] id_rs;
  logic [RegAddrW-1:0] id_rt;
  logic [RegAddrW-1:0] id_rd;
  logic                id_mc_issue;
  logic                rf_we;
  logic [RegAddrW-1:0] rf_waddr;
  logic [DataW-1:0]    rf_wdata;
  logic                c_stall;

  modport master (
    output cpu_stall, wb_rfw, wb_rf_waddr, wb_rf_wdata,
    output mc_valid, mc_waddr, mc_wdata,
    output id_valid, id_rs, id_rt, id_rd, id_mc_issue,
    input  mc_ready, rf_we, rf_waddr, rf_wdata, c_stall
  );

  modport slave (
    input  cpu_stall, wb_rfw, wb_rf_waddr, wb_rf_wdata,
    input  mc_valid, mc_waddr, mc_wdata,
    input  id_valid, id_rs, id_rt, id_rd, id_mc_issue,
    output mc_ready, rf_we, rf_waddr, rf_wdata, c_stall
  );

endinterface

// File: rtl/cpu_rf_wport_fifo.sv
// Parameterised synchronous FIFO holding multi-cycle results.
// Ports:
//   clk, rst      clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata   write request and data (ignored while full)
//   pop, rdata    read request (ignored while empty) and head data
//   full, empty   status flags
//   level         current occupancy
module cpu_rf_wport_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 37
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  level_q;
  logic             do_push, do_pop;

  assign full    = (level_q == LvlW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q <= level_q + LvlW'(do_push) - LvlW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/cpu_rf_wport_arb.sv
// Register-file write-port arbiter.
// Shares the single RF write port between the writeback stage (always first)
// and queued multi-cycle results, which drain into writeback bubbles. A
// scoreboard stalls decode on registers with outstanding multi-cycle results,
// and a starvation scheduler forces decode bubbles when the queue head waits
// too long.
// Ports:
//   clk, rst  clock, asynchronous active-low reset
//   bus       pipeline bundle (slave side): writeback, multi-cycle result,
//             decode operands, RF write port, decode stall
module cpu_rf_wport_arb
  import cpu_rf_wport_arb_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  cpu_rf_wport_arb_if.slave       bus
);

  localparam int unsigned LvlW = $clog2(DEPTH) + 1;
  localparam int unsigned CntW = $clog2(STARVE_MAX);

  mc_entry_t          head;
  logic [$bits(mc_entry_t)-1:0] fifo_rdata;
  logic               full, empty;
  logic [LvlW-1:0]    level, occ_next;
  logic               wb_sel, push, pop, issue;

  logic [NumRegs-1:1] pending_q, pending_d;
  logic [NumRegs-1:0] pend_vec, set_vec, clr_vec, upd_vec;
  logic               hazard;

  sched_state_e       state_q;
  logic [CntW-1:0]    cnt_q;

  cpu_rf_wport_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(mc_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({bus.mc_waddr, bus.mc_wdata}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign head = mc_entry_t'(fifo_rdata);

  // Write port: writeback wins; a queued result only fills a bubble.
  assign wb_sel       = bus.wb_rfw && (bus.wb_rf_waddr != RegZero);
  assign push         = bus.mc_valid && !full;
  // Under cpu_stall the writeback repeats, so the head must stay queued.
  assign pop          = !wb_sel && !empty && !bus.cpu_stall;
  assign bus.mc_ready = !full;
  assign bus.rf_we    = rst && (wb_sel || (!empty && (head.addr != RegZero)));
  assign bus.rf_waddr = wb_sel ? bus.wb_rf_waddr : head.addr;
  assign bus.rf_wdata = wb_sel ? bus.wb_rf_wdata : head.data;

  assign occ_next = level + LvlW'(push) - LvlW'(pop);

  // Scoreboard; bit 0 is tied low so r0 never reports a hazard.
  assign pend_vec = {pending_q, 1'b0};
  assign hazard   = pend_vec[bus.id_rs] || pend_vec[bus.id_rt] || pend_vec[bus.id_rd];
  assign bus.c_stall = (bus.id_valid && hazard) || (state_q == StStarve);

  assign issue = bus.id_mc_issue && bus.id_valid && !bus.c_stall && !bus.cpu_stall &&
                 (bus.id_rd != RegZero);

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue) set_vec[bus.id_rd] = 1'b1;
    if (pop)   clr_vec[head.addr] = 1'b1;
    upd_vec   = (pend_vec & ~clr_vec) | set_vec;
    pending_d = upd_vec[NumRegs-1:1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending_q <= '0;
    else      pending_q <= pending_d;
  end

  // Starvation scheduler; frozen while the pipeline is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else if (!bus.cpu_stall) begin
      unique case (state_q)
        StIdle: begin
          if (occ_next != '0) begin
            state_q <= StWait;
            cnt_q   <= '0;
          end
        end
        StWait: begin
          if (pop) begin
            cnt_q <= '0;
            if (occ_next == '0) state_q <= StIdle;
          end else if (cnt_q == CntW'(STARVE_MAX - 1)) begin
            state_q <= StStarve;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StStarve: begin
          if (pop) begin
            cnt_q   <= '0;
            state_q <= (occ_next == '0) ? StIdle : StWait;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/cpu_rf_wport_arb.md
Name: cpu_rf_wport_arb

Overview:
- Arbitrates the register file's single write port between the pipeline writeback stage and a multi-cycle execution unit (mul/div).
- The writeback stage always has priority. Multi-cycle results queue in a small FIFO and drain into writeback bubbles.
- A scoreboard tracks registers with an outstanding multi-cycle result and raises a decode stall on any dependency.
- A starvation counter forces decode bubbles so that queued results always drain.

Parameters:
- DEPTH, 2, multi-cycle result FIFO entries (power of 2, ≥2).
- STARVE_MAX, 8, cycles a FIFO head may wait before bubbles are forced.

Ports:
- clk  in  1  clock.
- rst  in  1  **asynchronous, active-low reset**.
- cpu_stall  in  1  global pipeline freeze.
- wb_rfw  in  1  writeback write enable.
- wb_rf_waddr  in  5  writeback destination register.
- wb_rf_wdata  in  32  writeback data.
- mc_valid  in  1  multi-cycle result valid.
- mc_waddr  in  5  multi-cycle destination register.
- mc_wdata  in  32  multi-cycle result data.
- mc_ready  out  1  FIFO can accept a result.
- id_valid  in  1  decode holds a real instruction.
- id_rs, id_rt, id_rd  in  5 each  decode source and destination registers.
- id_mc_issue  in  1  decode instruction is dispatched to the multi-cycle unit.
- rf_we  out  1  register file write enable.
- rf_waddr  out  5  register file write address.
- rf_wdata  out  32  register file write data.
- c_stall  out  1  decode stall request (scoreboard hazard or starvation).

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO empty; pending vector = 0; starve count = 0; state = IDLE.
  - mc_ready=1, rf_we=0, c_stall=0.
- Write port (combinational, same cycle):
  - If wb_rfw and wb_rf_waddr≠0: pass the writeback request through.
  - Else if FIFO non-empty: drive the FIFO head and pop it at the next posedge.
  - Else: rf_we=0.
  - Writes to r0 are never driven.
  - A pop is suppressed while cpu_stall=1, because the writeback stage repeats its write.
- FIFO:
  - mc_ready = !full.
  - Push on posedge when mc_valid & mc_ready.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - Pointers wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
  - Accept-to-write minimum latency: 1 cycle.
  - mc_valid while full: the producer holds its data; no loss, no overwrite.
- Scoreboard (31 pending bits, r1..r31):
  - Set pending[id_rd] on posedge when id_mc_issue & id_valid & !c_stall & !cpu_stall & id_rd≠0.
  - Clear pending[addr] on posedge of the cycle its FIFO entry is popped.
  - Set and clear can target the same register only across cycles: an issue to a pending rd always stalls.
  - Set and clear on different registers in the same cycle are both applied.
- Hazard output:
  - c_stall = id_valid & (pending[id_rs] | pending[id_rt] | pending[id_rd]), with r0 excluded, OR state==STARVE.
- Scheduler FSM (advances only when cpu_stall=0; the count freezes under stall):
  - IDLE: FIFO empty. Go to WAIT on push.
  - WAIT: count increments each cycle the head is not popped. Reset the count on pop. Go to IDLE when the FIFO is empty after a pop. Go to STARVE when count == STARVE_MAX-1.
  - STARVE: c_stall=1, which forces decode bubbles that reach writeback later. On a pop, clear the count and go to WAIT (FIFO still non-empty) or IDLE (FIFO empty).
- Pipeline flush does not affect pending bits: results already issued still complete and clear their bits.
- Reset in mid-operation discards FIFO contents. The multi-cycle unit is reset by the same rst.

Decomposition:
- Shared package:
  - register index width (5);
  - data width (32);
  - r0 constant;
  - FSM state encodings IDLE/WAIT/STARVE.
- One natural sub-module: cpu_rf_wport_fifo. It is a parameterised synchronous FIFO with full/empty outputs and the async active-low reset.

Test Plan:
- Basic drain: wb_rfw=0; mc_valid for r5=0x1234.
  - Cycle after accept: rf_we=1, rf_waddr=5, rf_wdata=0x1234.
  - pending[5] clears; FIFO empty; state IDLE.
- Writeback priority: wb_rfw=1 (r3=0xAA) continuously with FIFO holding r7.
  - rf_waddr=3 every cycle.
  - r7 is written only in the first cycle with wb_rfw=0.
- Scoreboard hazard: issue to r9, then id_rs=9.
  - c_stall=1 until the r9 result pops.
  - c_stall=0 in the cycle after the pop.
  - id_rs=0 never stalls.
- FIFO full: fill DEPTH=2 entries with wb_rfw held high.
  - mc_ready=0; a third mc_valid is held, not lost.
  - After one pop, mc_ready=1 and the third entry is accepted.
- Starvation: wb_rfw=1 always; FIFO non-empty.
  - After 8 cycles, state=STARVE and c_stall=1.
  - Once the bubble drops wb_rfw, the head pops and state returns to WAIT or IDLE.
- Async reset mid-drain: assert rst=0 between clock edges.
  - rf_we, mc_ready=1, c_stall=0 and pending=0 take effect immediately.
